and_input_debounce: RTL and testbench
=====================================

# and_input_debounce

Upstream conditioning stage for the `and_fixture` top level. Takes an asynchronous external pin, synchronises it into the `clock` domain and debounces it with a hold-counter state machine. Drives a clean single-bit `level` that feeds `and_fixture.a_in`. Also provides one-cycle `rise`/`fall` strobes and a saturating glitch counter for bring-up diagnostics.

## Interface

Parameters:
- `HOLD_CYCLES`, default 1000: consecutive synchronised samples at the new value required before `level` changes. Legal range is 1 ≤ HOLD_CYCLES < 2^CNT_W.
- `CNT_W`, default 10: width of the hold counter.

Ports:
- `clock`  in  1  the single clock; all state is updated on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `raw_in`  in  1  asynchronous external pin, with no timing relation to `clock`.
- `glitch_clear`  in  1  synchronous clear of `glitch_count`.
- `level`  out  1  debounced level; connects to `and_fixture.a_in`.
- `rise`  out  1  one-cycle pulse in the cycle `level` goes 0→1.
- `fall`  out  1  one-cycle pulse in the cycle `level` goes 1→0.
- `glitch_count`  out  8  count of aborted candidate transitions; saturates at 255.

## Operation

- **Synchroniser:** two flops, `sync1` then `sync2`. `s` = `sync2`. No logic is placed between the two flops.
- **FSM states:** `STABLE_LOW`, `CHECK_HIGH`, `STABLE_HIGH`, `CHECK_LOW`. `level` is 1 exactly in `STABLE_HIGH` and `CHECK_LOW`.
- **STABLE_LOW:**
  - s=0: stay.
  - s=1 and HOLD_CYCLES=1: go to STABLE_HIGH and assert `rise`.
  - s=1 otherwise: go to CHECK_HIGH with cnt=1.
- **CHECK_HIGH:**
  - s=0: return to STABLE_LOW and increment `glitch_count`.
  - s=1 and cnt+1=HOLD_CYCLES: go to STABLE_HIGH and assert `rise`.
  - s=1 otherwise: cnt=cnt+1.
- **STABLE_HIGH / CHECK_LOW:** mirror images of the above, with s inverted and `fall` asserted on the transition to STABLE_LOW.
- **Hold counter:** `cnt` is CNT_W bits and never wraps; it is compared only against HOLD_CYCLES. `cnt` is cleared to 0 on entry to any STABLE state.
- **glitch_count:** saturating increment. If `glitch_clear` and a glitch occur in the same cycle, `clear` wins and the result is 0.
- **Outputs:** `rise`, `fall` and `level` are registered, not decoded combinationally from `s`. `rise` and `fall` are never high together.

## Timing

- **Reset values (async, while reset_n=0):**
  - sync1 = sync2 = 0.
  - state = STABLE_LOW, cnt = 0.
  - level = 0, rise = 0, fall = 0, glitch_count = 0.
- **Reset release:** takes effect on the first rising edge after reset_n=1. No transition completes before s has been sampled HOLD_CYCLES times.
- **Reset mid-check:** any in-progress CHECK state is abandoned. This is not counted as a glitch.
- **Latency:** `raw_in` is stable and meets setup before edge 0.
  - s=1 after edge 1.
  - The FSM takes its first sample at edge 2.
  - `level` and `rise` are high after edge HOLD_CYCLES+1, i.e. HOLD_CYCLES+2 edges in total.
  - The same latency applies to falls.
- **Pulse width:** `rise`/`fall` are high for exactly one cycle.
- **Minimum interval between transitions:** HOLD_CYCLES cycles between a `rise` and the next `fall`.
- **Glitch width:** a pulse on s shorter than HOLD_CYCLES samples never changes `level`. Each such pulse adds exactly 1 to `glitch_count`.
- **Throughput:** one sample per cycle; there are no stalls.

## Test plan

All scenarios use HOLD_CYCLES=4 unless stated otherwise.

- **Reset:** assert reset_n=0 mid-CHECK_HIGH with glitch_count=3 → all outputs are 0 immediately, without waiting for a clock edge. After release, raw_in=1 held → level=1 and rise=1 after the 6th edge following release, and rise=0 on the next edge.
- **Clean edges:** raw_in 0→1 held, then 1→0 held → exactly one rise pulse at edge 5 after the change and one fall pulse at edge 5 after the change. glitch_count stays 0.
- **Bounce:** raw_in high for 3 cycles, low, then high for 3 cycles, low → level stays 0 and glitch_count=2. Then hold high for 4+ cycles → level=1 with exactly one rise.
- **Saturation and clear:**
  - Drive 300 three-cycle glitches → glitch_count=255, with no wrap to 0.
  - Assert glitch_clear together with a glitch on the same edge → glitch_count=0.
- **HOLD_CYCLES=1:** a one-cycle raw pulse (sampled) → level goes high and then low, producing rise then fall on consecutive transitions. glitch_count stays 0.
- **Random raw_in (10k cycles):** checked against a reference model. level changes only after 4 equal samples, rise/fall are never simultaneous, and level always equals the integral of rise−fall.

Source files
------------

// File: rtl/and_input_debounce.sv
// -----------------------------------------------------------------------------
// and_input_debounce
//
// Conditions an asynchronous external pin for the and_fixture top level.
// The pin passes through a two-flop synchroniser. A hold-counter state machine
// then debounces it and drives a clean, registered level. The block also gives
// one-cycle rise/fall strobes and a saturating count of aborted transitions,
// which is useful during board bring-up.
//
// Parameters
//   HOLD_CYCLES  consecutive synchronised samples at the new value needed
//                before level changes (1 <= HOLD_CYCLES < 2**CNT_W)
//   CNT_W        width of the hold counter
//
// Ports
//   clock         in   single clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   raw_in        in   asynchronous external pin
//   glitch_clear  in   synchronous clear of glitch_count (wins over increment)
//   level         out  debounced level (feeds and_fixture.a_in)
//   rise          out  one-cycle pulse when level goes 0->1
//   fall          out  one-cycle pulse when level goes 1->0
//   glitch_count  out  aborted candidate transitions, saturates at 255
// -----------------------------------------------------------------------------
module and_input_debounce #(
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       raw_in,
    input  logic       glitch_clear,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [7:0] glitch_count
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHECK_HIGH,
        STABLE_HIGH,
        CHECK_LOW
    } state_t;

    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             glitch;

    // Two plain flops back to back. Nothing may sit between them, so the
    // first flop has a full cycle to resolve metastability.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    assign s       = sync2;
    assign cnt_inc = cnt + CNT_W'(1);

    // A glitch is a candidate transition that the input abandoned before the
    // hold time ran out.
    always_comb begin
        glitch = 1'b0;
        if ((state == CHECK_HIGH) && !s)
            glitch = 1'b1;
        if ((state == CHECK_LOW) && s)
            glitch = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= STABLE_LOW;
            cnt          <= '0;
            level        <= 1'b0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            glitch_count <= 8'd0;
        end else begin
            // Strobes are high only in the cycle after the transition edge.
            rise <= 1'b0;
            fall <= 1'b0;

            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        if (HOLD_CYCLES == 1) begin
                            state <= STABLE_HIGH;
                            level <= 1'b1;
                            rise  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= CHECK_HIGH;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                CHECK_HIGH: begin
                    if (!s) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                    end else if (cnt_inc == HOLD) begin
                        state <= STABLE_HIGH;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        if (HOLD_CYCLES == 1) begin
                            state <= STABLE_LOW;
                            level <= 1'b0;
                            fall  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= CHECK_LOW;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                CHECK_LOW: begin
                    if (s) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt_inc == HOLD) begin
                        state <= STABLE_LOW;
                        level <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    level <= 1'b0;
                    cnt   <= '0;
                end
            endcase

            // Clear has priority so software can zero the count even while
            // the pin is still bouncing.
            if (glitch_clear)
                glitch_count <= 8'd0;
            else if (glitch && (glitch_count != 8'hFF))
                glitch_count <= glitch_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_and_input_debounce.sv
module tb_and_input_debounce;

    localparam int HOLD = 4;

    logic       clock;
    logic       reset_n;
    logic       raw4, clear4, raw1, clear1;
    logic       level4, rise4, fall4;
    logic       level1, rise1, fall1;
    logic [7:0] glitch4, glitch1;

    int tests;
    int failed;

    and_input_debounce #(.HOLD_CYCLES(HOLD), .CNT_W(10)) u4 (
        .clock(clock), .reset_n(reset_n), .raw_in(raw4), .glitch_clear(clear4),
        .level(level4), .rise(rise4), .fall(fall4), .glitch_count(glitch4)
    );

    and_input_debounce #(.HOLD_CYCLES(1), .CNT_W(4)) u1 (
        .clock(clock), .reset_n(reset_n), .raw_in(raw1), .glitch_clear(clear1),
        .level(level1), .rise(rise1), .fall(fall1), .glitch_count(glitch1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state for the random phase
    bit       m_sync1, m_sync2, m_s, m_level, m_rise, m_fall;
    int       m_run;
    int       m_glitch;
    int       integ;
    int       rise_cnt;

    initial begin
        tests   = 0;
        failed  = 0;
        reset_n = 1'b0;
        raw4    = 1'b0;
        clear4  = 1'b0;
        raw1    = 1'b0;
        clear1  = 1'b0;

        // Reset state
        tick(2);
        check("rst_level", 32'(level4), 0);
        check("rst_rise", 32'(rise4), 0);
        check("rst_fall", 32'(fall4), 0);
        check("rst_glitch", 32'(glitch4), 0);

        // Clean rising edge: release and raw high before edge 0
        reset_n = 1'b1;
        raw4    = 1'b1;
        tick(5);
        check("clean_rise_e4_level", 32'(level4), 0);
        check("clean_rise_e4_rise", 32'(rise4), 0);
        tick(1);
        check("clean_rise_e5_level", 32'(level4), 1);
        check("clean_rise_e5_rise", 32'(rise4), 1);
        check("clean_rise_e5_fall", 32'(fall4), 0);
        tick(1);
        check("clean_rise_e6_rise", 32'(rise4), 0);
        check("clean_rise_e6_level", 32'(level4), 1);
        tick(3);

        // Clean falling edge
        raw4 = 1'b0;
        tick(5);
        check("clean_fall_e4_level", 32'(level4), 1);
        check("clean_fall_e4_fall", 32'(fall4), 0);
        tick(1);
        check("clean_fall_e5_level", 32'(level4), 0);
        check("clean_fall_e5_fall", 32'(fall4), 1);
        check("clean_fall_e5_rise", 32'(rise4), 0);
        tick(1);
        check("clean_fall_e6_fall", 32'(fall4), 0);
        check("clean_glitch", 32'(glitch4), 0);

        // Bounce: two 3-cycle pulses
        raw4 = 1'b1; tick(3); raw4 = 1'b0; tick(6);
        check("bounce1_glitch", 32'(glitch4), 1);
        check("bounce1_level", 32'(level4), 0);
        raw4 = 1'b1; tick(3); raw4 = 1'b0; tick(6);
        check("bounce2_glitch", 32'(glitch4), 2);
        check("bounce2_level", 32'(level4), 0);

        // Then a real hold: exactly one rise
        rise_cnt = 0;
        raw4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            rise_cnt += int'(rise4);
        end
        check("hold_level", 32'(level4), 1);
        check("hold_rise_count", 32'(rise_cnt), 1);
        check("hold_glitch", 32'(glitch4), 2);
        raw4 = 1'b0;
        tick(10);
        check("hold_fall_level", 32'(level4), 0);

        // Third glitch, then reset in the middle of CHECK_HIGH
        raw4 = 1'b1; tick(3); raw4 = 1'b0; tick(6);
        check("pre_reset_glitch", 32'(glitch4), 3);
        raw4 = 1'b1;
        tick(4);
        reset_n = 1'b0;
        #2;
        check("async_rst_level", 32'(level4), 0);
        check("async_rst_rise", 32'(rise4), 0);
        check("async_rst_fall", 32'(fall4), 0);
        check("async_rst_glitch", 32'(glitch4), 0);
        reset_n = 1'b1;
        tick(5);
        check("post_rst_e4_level", 32'(level4), 0);
        tick(1);
        check("post_rst_e5_level", 32'(level4), 1);
        check("post_rst_e5_rise", 32'(rise4), 1);
        check("post_rst_glitch", 32'(glitch4), 0);
        tick(1);
        check("post_rst_e6_rise", 32'(rise4), 0);

        // Saturation
        raw4 = 1'b0;
        tick(10);
        check("sat_start_level", 32'(level4), 0);
        for (int g = 1; g <= 300; g++) begin
            raw4 = 1'b1; tick(3); raw4 = 1'b0; tick(3);
            if (g == 254) check("sat_254", 32'(glitch4), 254);
            if (g == 255) check("sat_255", 32'(glitch4), 255);
        end
        check("sat_300", 32'(glitch4), 255);
        check("sat_level", 32'(level4), 0);

        // Clear on the same edge as a glitch
        raw4 = 1'b1; tick(3); raw4 = 1'b0; tick(2);
        clear4 = 1'b1;
        tick(1);
        clear4 = 1'b0;
        check("clear_wins", 32'(glitch4), 0);
        tick(3);
        raw4 = 1'b1; tick(3); raw4 = 1'b0; tick(3);
        check("after_clear_glitch", 32'(glitch4), 1);

        // HOLD_CYCLES = 1: single sampled pulse
        raw1 = 1'b1;
        tick(1);
        raw1 = 1'b0;
        tick(1);
        check("h1_e1_level", 32'(level1), 0);
        tick(1);
        check("h1_e2_level", 32'(level1), 1);
        check("h1_e2_rise", 32'(rise1), 1);
        check("h1_e2_fall", 32'(fall1), 0);
        tick(1);
        check("h1_e3_level", 32'(level1), 0);
        check("h1_e3_fall", 32'(fall1), 1);
        check("h1_e3_rise", 32'(rise1), 0);
        tick(1);
        check("h1_e4_fall", 32'(fall1), 0);
        check("h1_glitch", 32'(glitch1), 0);

        // Random raw_in against a reference model
        raw4    = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n  = 1'b1;
        m_sync1  = 0;
        m_sync2  = 0;
        m_level  = 0;
        m_run    = 0;
        m_glitch = 0;
        integ    = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(2) == 0) raw4 = ~raw4;
            @(posedge clock);
            m_s     = m_sync2;
            m_sync2 = m_sync1;
            m_sync1 = raw4;
            m_rise  = 0;
            m_fall  = 0;
            if (m_s != m_level) begin
                m_run++;
                if (m_run == HOLD) begin
                    m_level = m_s;
                    m_rise  = m_s;
                    m_fall  = !m_s;
                    m_run   = 0;
                end
            end else begin
                if (m_run != 0 && m_glitch != 255) m_glitch++;
                m_run = 0;
            end
            #1;
            integ += int'(rise4) - int'(fall4);
            check("rnd_level", 32'(level4), 32'(m_level));
            check("rnd_rise", 32'(rise4), 32'(m_rise));
            check("rnd_fall", 32'(fall4), 32'(m_fall));
            check("rnd_glitch", 32'(glitch4), 32'(m_glitch));
            check("rnd_rise_fall_excl", 32'(rise4 & fall4), 0);
            check("rnd_integral", 32'(integ), 32'(level4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
